modn_counter_chain: RTL

Parametrised multi-digit modulo-N counter: NDIGITS cascaded digits, each counting 0..MAXIMUM_VALUE, with up/down direction, synchronous load and clear, and a chain-level carry/borrow pulse. Replaces the divided-clock scheme with a single-clock design: an internal prescaler produces a one-cycle step enable, so every register runs on clk. Sits between board I/O (switches and buttons) and display/decoder logic, or as a timebase for other blocks.

---
 rtl/counter_pkg.sv | 22 ++
 rtl/tick_prescaler.sv | 30 +++
 rtl/modn_counter_chain.sv | 100 ++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-N counter chain.
// Direction encoding, prescaler width and digit saturation.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'(1) << w) < 64'(n)) w++;
    return w;
  endfunction

  function automatic int unsigned sat_digit(
    input int unsigned v,
    input int unsigned max_v
  );
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle step enable.
// Holds while disabled; restart forces it back to zero.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned TICK_DIVISOR = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic step
);

  localparam int unsigned PW = clog2_min1(TICK_DIVISOR);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIVISOR - 1);

  logic [PW-1:0] cnt;

  assign step = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset || restart || step) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/modn_counter_chain.sv
// Cascaded modulo-N digit counter, single clock, prescaled steps.
// Up/down, saturating load, clear and full-chain carry pulse.
module modn_counter_chain
  import counter_pkg::*;
#(
  parameter int unsigned NDIGITS       = 4,
  parameter int unsigned DIGIT_BITS    = 4,
  parameter int unsigned MAXIMUM_VALUE = 9,
  parameter int unsigned TICK_DIVISOR  = 10000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          up_down,
  input  logic                          load,
  input  logic [NDIGITS*DIGIT_BITS-1:0] load_value,
  input  logic                          clear,
  output logic [NDIGITS*DIGIT_BITS-1:0] count,
  output logic                          tick,
  output logic                          carry
);

  localparam logic [DIGIT_BITS-1:0] DMAX =
    DIGIT_BITS'(MAXIMUM_VALUE);

  logic               step;
  logic               restart;
  logic               wrap;
  logic [NDIGITS:0]   lo_max;
  logic [NDIGITS:0]   lo_zero;

  assign restart = clear | load;

  tick_prescaler #(
    .TICK_DIVISOR(TICK_DIVISOR)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .restart(restart),
    .step   (step)
  );

  // lo_max[i]/lo_zero[i]: every digit below i is at its wrap point
  always_comb begin
    lo_max  = '0;
    lo_zero = '0;
    lo_max[0]  = 1'b1;
    lo_zero[0] = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      lo_max[i+1] = lo_max[i] &&
        (count[i*DIGIT_BITS +: DIGIT_BITS] == DMAX);
      lo_zero[i+1] = lo_zero[i] &&
        (count[i*DIGIT_BITS +: DIGIT_BITS] == '0);
    end
  end

  assign wrap = (up_down == DIR_UP) ?
    lo_max[NDIGITS] : lo_zero[NDIGITS];

  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    logic [DIGIT_BITS-1:0] d;
    logic [DIGIT_BITS-1:0] ld_val;
    logic                  adv;

    assign ld_val = DIGIT_BITS'(sat_digit(
      32'(load_value[i*DIGIT_BITS +: DIGIT_BITS]),
      MAXIMUM_VALUE));

    assign adv = step &&
      ((up_down == DIR_UP) ? lo_max[i] : lo_zero[i]);

    always_ff @(posedge clk) begin
      if (!reset || clear) begin
        d <= '0;
      end else if (load) begin
        d <= ld_val;
      end else if (adv) begin
        if (up_down == DIR_UP) begin
          d <= (d == DMAX) ? '0 : d + 1'b1;
        end else begin
          d <= (d == '0) ? DMAX : d - 1'b1;
        end
      end
    end

    assign count[i*DIGIT_BITS +: DIGIT_BITS] = d;
  end

  always_ff @(posedge clk) begin
    if (!reset || restart) begin
      tick  <= 1'b0;
      carry <= 1'b0;
    end else begin
      tick  <= step;
      carry <= step && wrap;
    end
  end

endmodule
